// File: rtl/cachepool_pkg.sv
// Shared types for the cache refill path.
// Holds the reqrsp refill request/response structs, the refill user tag
// (bank id + cache info), the AXI structs of the IWC output bus and the
// refill FSM state encoding.
package cachepool_pkg;

    localparam int unsigned AddrWidth         = 32;
    localparam int unsigned SpatzAxiDataWidth = 128;
    localparam int unsigned SpatzAxiStrbWidth = SpatzAxiDataWidth / 8;
    localparam int unsigned IwcAxiIdOutWidth  = 3;
    localparam int unsigned RefillAxiSize     = $clog2(SpatzAxiStrbWidth);

    localparam logic [1:0] AxiBurstIncr  = 2'b01;
    localparam logic [1:0] AxiRespOkay   = 2'b00;
    localparam logic [1:0] AxiRespSlvErr = 2'b10;

    typedef logic [IwcAxiIdOutWidth-1:0]  axi_id_t;
    typedef logic [AddrWidth-1:0]         axi_addr_t;
    typedef logic [SpatzAxiDataWidth-1:0] axi_data_t;
    typedef logic [SpatzAxiStrbWidth-1:0] axi_strb_t;

    typedef struct packed {
        logic [3:0] depth;
        logic [1:0] way;
    } cache_info_t;

    typedef struct packed {
        logic [3:0]  bank_id;
        cache_info_t info;
    } refill_user_t;

    typedef struct packed {
        axi_addr_t    addr;
        logic         write;
        axi_data_t    data;
        axi_strb_t    strb;
        refill_user_t user;
    } cache_trans_req_chan_t;

    typedef struct packed {
        axi_data_t    data;
        logic         error;
        refill_user_t user;
    } cache_trans_rsp_chan_t;

    typedef struct packed {
        cache_trans_req_chan_t q;
        logic                  q_valid;
        logic                  p_ready;
    } cache_trans_req_t;

    typedef struct packed {
        cache_trans_rsp_chan_t p;
        logic                  p_valid;
        logic                  q_ready;
    } cache_trans_rsp_t;

    typedef struct packed {
        axi_id_t    id;
        axi_addr_t  addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [5:0] atop;
        logic       user;
    } axi_aw_chan_t;

    typedef struct packed {
        axi_data_t data;
        axi_strb_t strb;
        logic      last;
        logic      user;
    } axi_w_chan_t;

    typedef struct packed {
        axi_id_t    id;
        logic [1:0] resp;
        logic       user;
    } axi_b_chan_t;

    typedef struct packed {
        axi_id_t    id;
        axi_addr_t  addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic       user;
    } axi_ar_chan_t;

    typedef struct packed {
        axi_id_t    id;
        axi_data_t  data;
        logic [1:0] resp;
        logic       last;
        logic       user;
    } axi_r_chan_t;

    typedef struct packed {
        axi_aw_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } spatz_axi_iwc_out_req_t;

    typedef struct packed {
        logic         aw_ready;
        logic         ar_ready;
        logic         w_ready;
        logic         b_valid;
        axi_b_chan_t  b;
        logic         r_valid;
        axi_r_chan_t  r;
    } spatz_axi_iwc_out_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND_RD = 2'd1,
        ST_SEND_WR = 2'd2
    } refill_state_e;

endpackage

// File: rtl/cache_refill_id_table.sv
// Outstanding-transaction table of the refill bridge.
// Ports: alloc_* claims the lowest-index free entry (index on alloc_idx_o);
// lookup_idx_i selects the entry addressed by a returning AXI ID, free_i
// releases that same entry; full_o / empty_o summarise occupancy.
module cache_refill_id_table
    import cachepool_pkg::*;
#(
    parameter int unsigned NumEntries = 8,
    localparam int unsigned IdxWidth  = $clog2(NumEntries)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alloc_i,
    input  logic                alloc_write_i,
    input  refill_user_t        alloc_user_i,
    output logic [IdxWidth-1:0] alloc_idx_o,
    input  logic [IdxWidth-1:0] lookup_idx_i,
    output logic                lookup_valid_o,
    output logic                lookup_write_o,
    output refill_user_t        lookup_user_o,
    input  logic                free_i,
    output logic                full_o,
    output logic                empty_o
);

    logic [NumEntries-1:0] valid_q, valid_d;
    logic [NumEntries-1:0] write_q;
    refill_user_t          user_q [NumEntries];

    // Priority find of the first cleared valid bit; scanning downward lets
    // the lowest free index win.
    always_comb begin
        alloc_idx_o = '0;
        for (int i = NumEntries - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx_o = IdxWidth'(i);
        end
    end

    assign full_o         = &valid_q;
    assign empty_o        = ~|valid_q;
    assign lookup_valid_o = valid_q[lookup_idx_i];
    assign lookup_write_o = write_q[lookup_idx_i];
    assign lookup_user_o  = user_q[lookup_idx_i];

    // An entry being freed is still valid, so it can never be the one
    // allocated in the same cycle; reuse happens from the next cycle on.
    always_comb begin
        valid_d = valid_q;
        if (free_i)  valid_d[lookup_idx_i] = 1'b0;
        if (alloc_i) valid_d[alloc_idx_o]  = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            write_q <= '0;
            user_q  <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            if (alloc_i) begin
                write_q[alloc_idx_o] <= alloc_write_i;
                user_q[alloc_idx_o]  <= alloc_user_i;
            end
        end
    end

endmodule

// File: rtl/cache_refill_axi_bridge.sv
// Converts one cache refill/writeback reqrsp request into one single-beat
// 128-bit AXI4 transaction and returns the tagged response.
// Ports: req_i/rsp_o - reqrsp refill port of the L1 controller;
// axi_req_o/axi_rsp_i - IWC AXI master toward crossbar/L2;
// busy_o - any transaction outstanding.
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | ready for a new request (table and buffer allowing)
// ST_SEND_RD | presenting AR until accepted
// ST_SEND_WR | presenting AW and W, each until its own handshake
module cache_refill_axi_bridge
    import cachepool_pkg::*;
#(
    parameter int unsigned NumOutstanding = 8,
    parameter int unsigned AxiIdWidth     = IwcAxiIdOutWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  cache_trans_req_t        req_i,
    output cache_trans_rsp_t        rsp_o,
    output spatz_axi_iwc_out_req_t  axi_req_o,
    input  spatz_axi_iwc_out_resp_t axi_rsp_i,
    output logic                    busy_o
);

    localparam int unsigned IdxWidth = $clog2(NumOutstanding);

    refill_state_e         state_q, state_d;
    logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                  en_q;
    axi_addr_t             addr_q;
    axi_data_t             data_q;
    axi_strb_t             strb_q;
    logic [IdxWidth-1:0]   id_q, alloc_idx, lookup_idx;
    logic [AxiIdWidth-1:0] axi_id;
    logic                  q_ready, alloc, ar_valid, aw_valid, w_valid;
    logic                  tbl_full, tbl_empty, lookup_valid, lookup_write;
    refill_user_t          lookup_user;
    logic                  buf_space, r_ready, b_ready, r_hs, b_hs, rsp_hs, rsp_load;
    axi_id_t               rsp_id;
    logic                  p_valid_q;
    cache_trans_rsp_chan_t p_q;
    logic                  unused_ok;

    cache_refill_id_table #(.NumEntries(NumOutstanding)) i_id_table (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .alloc_i        (alloc),
        .alloc_write_i  (req_i.q.write),
        .alloc_user_i   (req_i.q.user),
        .alloc_idx_o    (alloc_idx),
        .lookup_idx_i   (lookup_idx),
        .lookup_valid_o (lookup_valid),
        .lookup_write_o (lookup_write),
        .lookup_user_o  (lookup_user),
        .free_i         (rsp_load),
        .full_o         (tbl_full),
        .empty_o        (tbl_empty)
    );

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        q_ready   = 1'b0;
        alloc     = 1'b0;
        ar_valid  = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                q_ready = en_q && !tbl_full && buf_space;
                if (req_i.q_valid && q_ready) begin
                    alloc     = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_i.q.write ? ST_SEND_WR : ST_SEND_RD;
                end
            end
            ST_SEND_RD: begin
                ar_valid = 1'b1;
                if (axi_rsp_i.ar_ready) state_d = ST_IDLE;
            end
            ST_SEND_WR: begin
                aw_valid = !aw_done_q;
                w_valid  = !w_done_q;
                if (aw_valid && axi_rsp_i.aw_ready) aw_done_d = 1'b1;
                if (w_valid && axi_rsp_i.w_ready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)          state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // en_q keeps q_ready low while in reset and for the first cycle after it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            en_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            en_q      <= 1'b1;
            if (alloc) begin
                addr_q <= req_i.q.addr & ~(AddrWidth'(SpatzAxiStrbWidth - 1));
                data_q <= req_i.q.data;
                strb_q <= req_i.q.strb;
                id_q   <= alloc_idx;
            end
        end
    end

    assign axi_id = AxiIdWidth'(id_q);

    always_comb begin
        axi_req_o          = '0;
        axi_req_o.ar.id    = axi_id;
        axi_req_o.ar.addr  = addr_q;
        axi_req_o.ar.size  = 3'(RefillAxiSize);
        axi_req_o.ar.burst = AxiBurstIncr;
        axi_req_o.ar.cache = 4'b0011;
        axi_req_o.ar_valid = ar_valid;
        axi_req_o.aw.id    = axi_id;
        axi_req_o.aw.addr  = addr_q;
        axi_req_o.aw.size  = 3'(RefillAxiSize);
        axi_req_o.aw.burst = AxiBurstIncr;
        axi_req_o.aw.cache = 4'b0011;
        axi_req_o.aw_valid = aw_valid;
        axi_req_o.w.data   = data_q;
        axi_req_o.w.strb   = strb_q;
        axi_req_o.w.last   = 1'b1;
        axi_req_o.w_valid  = w_valid;
        axi_req_o.r_ready  = r_ready;
        axi_req_o.b_ready  = b_ready;
    end

    // R has priority over B; B is held off whenever R is presented.
    assign buf_space  = !p_valid_q;
    assign r_ready    = buf_space;
    assign b_ready    = buf_space && !axi_rsp_i.r_valid;
    assign r_hs       = axi_rsp_i.r_valid && r_ready;
    assign b_hs       = axi_rsp_i.b_valid && b_ready;
    assign rsp_hs     = r_hs || b_hs;
    assign rsp_id     = r_hs ? axi_rsp_i.r.id : axi_rsp_i.b.id;
    assign lookup_idx = IdxWidth'(rsp_id);
    // A response for an unallocated ID is dropped and leaves the table alone.
    assign rsp_load   = rsp_hs && lookup_valid;

    // One-entry response buffer; it only loads when empty, so load and
    // drain never coincide.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_valid_q <= 1'b0;
            p_q       <= '0;
        end else if (rsp_load) begin
            p_valid_q <= 1'b1;
            p_q.data  <= r_hs ? axi_rsp_i.r.data : '0;
            p_q.error <= (r_hs ? axi_rsp_i.r.resp : axi_rsp_i.b.resp) != AxiRespOkay;
            p_q.user  <= lookup_user;
        end else if (p_valid_q && req_i.p_ready) begin
            p_valid_q <= 1'b0;
        end
    end

    assign rsp_o.p       = p_q;
    assign rsp_o.p_valid = p_valid_q;
    assign rsp_o.q_ready = q_ready;
    assign busy_o        = !tbl_empty;

    assign unused_ok = ^{axi_rsp_i.r.last, axi_rsp_i.r.user, axi_rsp_i.b.user, lookup_write};

    assert property (@(posedge clk_i) disable iff (!rst_ni) rsp_hs |-> lookup_valid)
        else $error("AXI response carries an ID with no outstanding entry");
    assert property (@(posedge clk_i) disable iff (!rst_ni) rsp_load |-> (lookup_write == b_hs))
        else $error("AXI response channel does not match the entry direction");

endmodule

// File: tb/tb_cache_refill_axi_bridge.sv
module tb_cache_refill_axi_bridge;
    import cachepool_pkg::*;

    logic                    clk_i = 1'b0;
    logic                    rst_ni = 1'b0;
    cache_trans_req_t        req;
    cache_trans_rsp_t        rsp;
    spatz_axi_iwc_out_req_t  axi_req;
    spatz_axi_iwc_out_resp_t axi_rsp;
    logic                    busy;

    int n_cmp = 0;
    int n_err = 0;
    int aw_cnt = 0;
    int w_cnt = 0;
    cache_trans_rsp_chan_t exp_q[$];
    refill_user_t          ent_user [8];

    cache_refill_axi_bridge dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req),
        .rsp_o     (rsp),
        .axi_req_o (axi_req),
        .axi_rsp_i (axi_rsp),
        .busy_o    (busy)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (axi_req.aw_valid && axi_rsp.aw_ready) aw_cnt++;
        if (axi_req.w_valid && axi_rsp.w_ready)   w_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_req(input logic [31:0] addr, input logic wr, input axi_data_t data,
                            input axi_strb_t strb, input refill_user_t user, output bit ok);
        int n = 0;
        @(posedge clk_i); #1;
        req.q.addr = addr; req.q.write = wr; req.q.data = data;
        req.q.strb = strb; req.q.user = user; req.q_valid = 1'b1;
        @(negedge clk_i);
        while (!rsp.q_ready && n < 50) begin @(negedge clk_i); n++; end
        ok = rsp.q_ready;
        @(posedge clk_i); #1;
        req.q_valid = 1'b0;
    endtask

    task automatic take_ar(output axi_ar_chan_t ar, output int lat, output bit ok);
        int n = 0;
        @(negedge clk_i);
        while (!axi_req.ar_valid && n < 20) begin @(negedge clk_i); n++; end
        ok = axi_req.ar_valid; ar = axi_req.ar; lat = n;
        axi_rsp.ar_ready = 1'b1;
        @(posedge clk_i); #1;
        axi_rsp.ar_ready = 1'b0;
    endtask

    task automatic drive_resp(input bit is_r, input int id, input axi_data_t data,
                              input logic [1:0] resp, output bit ok);
        int n = 0;
        @(posedge clk_i); #1;
        if (is_r) begin
            axi_rsp.r.id = axi_id_t'(id); axi_rsp.r.data = data; axi_rsp.r.resp = resp;
            axi_rsp.r.last = 1'b1; axi_rsp.r_valid = 1'b1;
        end else begin
            axi_rsp.b.id = axi_id_t'(id); axi_rsp.b.resp = resp; axi_rsp.b_valid = 1'b1;
        end
        @(negedge clk_i);
        while (!(is_r ? axi_req.r_ready : axi_req.b_ready) && n < 50) begin @(negedge clk_i); n++; end
        ok = is_r ? axi_req.r_ready : axi_req.b_ready;
        @(posedge clk_i); #1;
        axi_rsp.r_valid = 1'b0; axi_rsp.b_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        int n = 0;
        @(negedge clk_i);
        while (!(rsp.p_valid && req.p_ready) && n < 50) begin @(negedge clk_i); n++; end
        ok = rsp.p_valid && req.p_ready;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if ({rsp.q_ready, rsp.p_valid, axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid} !== 5'b0) begin
            n_err++; $display("FAIL rst_valids: got %b want 00000",
                {rsp.q_ready, rsp.p_valid, axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid});
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        @(posedge clk_i); #1; rst_ni = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (rsp.q_ready !== 1'b0) begin n_err++; $display("FAIL rst_first_cycle_qready: got %b want 0", rsp.q_ready); end
        @(negedge clk_i);
        n_cmp++;
        if (rsp.q_ready !== 1'b1) begin n_err++; $display("FAIL rst_qready_after: got %b want 1", rsp.q_ready); end
    endtask

    task automatic test_read();
        bit ok; int lat; axi_ar_chan_t ar; cache_trans_rsp_chan_t e;
        refill_user_t u = '{bank_id: 4'd2, info: '{depth: 4'd5, way: 2'd1}};
        axi_data_t d = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
        send_req(32'h8000_0010, 1'b0, '0, '0, u, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rd_accept: got 0 want 1"); end
        take_ar(ar, lat, ok);
        n_cmp++; if (!ok || lat != 0) begin n_err++; $display("FAIL rd_ar_latency: got %0d want 0 (seen %b)", lat, ok); end
        n_cmp++; if (ar.addr !== 32'h8000_0010) begin n_err++; $display("FAIL rd_ar_addr: got %h want 80000010", ar.addr); end
        n_cmp++; if (ar.id !== 3'd0) begin n_err++; $display("FAIL rd_ar_id: got %0d want 0", ar.id); end
        n_cmp++;
        if ({ar.len, ar.size, ar.burst, ar.cache} !== {8'd0, 3'd4, 2'b01, 4'b0011}) begin
            n_err++; $display("FAIL rd_ar_fields: got len %0d size %0d burst %0d cache %h want 0 4 1 3",
                ar.len, ar.size, ar.burst, ar.cache);
        end
        exp_q.push_back('{data: d, error: 1'b0, user: u});
        drive_resp(1'b1, 0, d, AxiRespOkay, ok);
        wait_rsp(ok);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || rsp.p !== e) begin n_err++; $display("FAIL rd_rsp: got %h want %h", rsp.p, e); end
    endtask

    task automatic test_write();
        bit ok; int aw0, w0; cache_trans_rsp_chan_t e;
        refill_user_t u = '{bank_id: 4'd1, info: '{depth: 4'd3, way: 2'd2}};
        axi_data_t d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        aw0 = aw_cnt; w0 = w_cnt;
        send_req(32'h8000_0104, 1'b1, d, 16'h00FF, u, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wr_accept: got 0 want 1"); end
        @(negedge clk_i);
        n_cmp++;
        if ({axi_req.aw_valid, axi_req.w_valid} !== 2'b11) begin
            n_err++; $display("FAIL wr_valids_start: got %b want 11", {axi_req.aw_valid, axi_req.w_valid});
        end
        n_cmp++;
        if (axi_req.aw.addr !== 32'h8000_0100 || axi_req.aw.id !== 3'd0 || axi_req.aw.size !== 3'd4) begin
            n_err++; $display("FAIL wr_aw_fields: got addr %h id %0d size %0d want 80000100 0 4",
                axi_req.aw.addr, axi_req.aw.id, axi_req.aw.size);
        end
        n_cmp++;
        if (axi_req.w.data !== d || axi_req.w.strb !== 16'h00FF || axi_req.w.last !== 1'b1) begin
            n_err++; $display("FAIL wr_w_fields: got strb %h last %b want 00ff 1", axi_req.w.strb, axi_req.w.last);
        end
        axi_rsp.w_ready = 1'b1;
        @(posedge clk_i); #1; axi_rsp.w_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if ({axi_req.aw_valid, axi_req.w_valid} !== 2'b10) begin
                n_err++; $display("FAIL wr_w_first_hold%0d: got %b want 10", i, {axi_req.aw_valid, axi_req.w_valid});
            end
        end
        axi_rsp.aw_ready = 1'b1;
        @(posedge clk_i); #1; axi_rsp.aw_ready = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if ({axi_req.aw_valid, axi_req.w_valid} !== 2'b00 || aw_cnt - aw0 != 1 || w_cnt - w0 != 1) begin
            n_err++; $display("FAIL wr_one_each: got valids %b aw %0d w %0d want 00 1 1",
                {axi_req.aw_valid, axi_req.w_valid}, aw_cnt - aw0, w_cnt - w0);
        end
        exp_q.push_back('{data: '0, error: 1'b0, user: u});
        drive_resp(1'b0, 0, '0, AxiRespOkay, ok);
        wait_rsp(ok);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || rsp.p !== e) begin n_err++; $display("FAIL wr_rsp: got %h want %h", rsp.p, e); end
    endtask

    task automatic test_full();
        bit ok; int lat; axi_ar_chan_t ar; cache_trans_rsp_chan_t e;
        refill_user_t u9 = '{bank_id: 4'd9, info: '{depth: 4'd9, way: 2'd3}};
        bit saw_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ent_user[i] = '{bank_id: 4'(i), info: '{depth: 4'(15 - i), way: 2'(i)}};
            send_req(32'h9000_0000 + 32'(i * 16), 1'b0, '0, '0, ent_user[i], ok);
            take_ar(ar, lat, ok);
            n_cmp++; if (!ok || ar.id !== 3'(i)) begin n_err++; $display("FAIL full_id%0d: got %0d want %0d", i, ar.id, i); end
        end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy: got %b want 1", busy); end
        @(posedge clk_i); #1;
        req.q.addr = 32'h9000_1000; req.q.write = 1'b0; req.q.user = u9; req.q_valid = 1'b1;
        repeat (3) begin @(negedge clk_i); if (rsp.q_ready) saw_ready = 1'b1; end
        n_cmp++; if (saw_ready !== 1'b0) begin n_err++; $display("FAIL full_qready: got 1 want 0"); end
        exp_q.push_back('{data: {4{32'hA000_0003}}, error: 1'b0, user: ent_user[3]});
        drive_resp(1'b1, 3, {4{32'hA000_0003}}, AxiRespOkay, ok);
        wait_rsp(ok);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || rsp.p !== e) begin n_err++; $display("FAIL full_rsp3: got %h want %h", rsp.p, e); end
        ent_user[3] = u9;
        send_req(32'h9000_1000, 1'b0, '0, '0, u9, ok);
        take_ar(ar, lat, ok);
        n_cmp++; if (!ok || ar.id !== 3'd3) begin n_err++; $display("FAIL full_reuse_id: got %0d want 3", ar.id); end
        for (int k = 7; k >= 0; k--) begin
            exp_q.push_back('{data: {4{32'hA000_0000 + 32'(k)}}, error: 1'b0, user: ent_user[k]});
            drive_resp(1'b1, k, {4{32'hA000_0000 + 32'(k)}}, AxiRespOkay, ok);
            wait_rsp(ok);
            e = exp_q.pop_front();
            n_cmp++; if (!ok || rsp.p !== e) begin n_err++; $display("FAIL drain_rsp%0d: got %h want %h", k, rsp.p, e); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drain_busy: got %b want 0", busy); end
    endtask

    task automatic test_collision();
        bit ok; int lat, aw0, w0, n; axi_ar_chan_t ar; cache_trans_rsp_chan_t e;
        bit stable = 1'b1;
        refill_user_t u0 = '{bank_id: 4'd4, info: '{depth: 4'd1, way: 2'd0}};
        refill_user_t u1 = '{bank_id: 4'd5, info: '{depth: 4'd2, way: 2'd1}};
        refill_user_t u2 = '{bank_id: 4'd6, info: '{depth: 4'd3, way: 2'd2}};
        axi_data_t d1 = {4{32'h1111_C0DE}};
        send_req(32'hA000_0000, 1'b0, '0, '0, u0, ok); take_ar(ar, lat, ok);
        send_req(32'hA000_0010, 1'b0, '0, '0, u1, ok); take_ar(ar, lat, ok);
        n_cmp++; if (!ok || ar.id !== 3'd1) begin n_err++; $display("FAIL col_rd_id: got %0d want 1", ar.id); end
        aw0 = aw_cnt; w0 = w_cnt;
        send_req(32'hA000_0020, 1'b1, {4{32'h5A5A_5A5A}}, 16'hFFFF, u2, ok);
        @(negedge clk_i);
        axi_rsp.aw_ready = 1'b1; axi_rsp.w_ready = 1'b1;
        @(posedge clk_i); #1; axi_rsp.aw_ready = 1'b0; axi_rsp.w_ready = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if ({axi_req.aw_valid, axi_req.w_valid} !== 2'b00 || aw_cnt - aw0 != 1 || w_cnt - w0 != 1) begin
            n_err++; $display("FAIL col_same_cycle_wr: got valids %b aw %0d w %0d want 00 1 1",
                {axi_req.aw_valid, axi_req.w_valid}, aw_cnt - aw0, w_cnt - w0);
        end
        req.p_ready = 1'b0;
        exp_q.push_back('{data: d1, error: 1'b0, user: u1});
        exp_q.push_back('{data: '0, error: 1'b0, user: u2});
        @(posedge clk_i); #1;
        axi_rsp.r.id = 3'd1; axi_rsp.r.data = d1; axi_rsp.r.resp = AxiRespOkay; axi_rsp.r.last = 1'b1; axi_rsp.r_valid = 1'b1;
        axi_rsp.b.id = 3'd2; axi_rsp.b.resp = AxiRespOkay; axi_rsp.b_valid = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if ({axi_req.r_ready, axi_req.b_ready} !== 2'b10) begin
            n_err++; $display("FAIL col_ready: got r/b %b want 10", {axi_req.r_ready, axi_req.b_ready});
        end
        @(posedge clk_i); #1; axi_rsp.r_valid = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            if (!rsp.p_valid || rsp.p !== exp_q[0] || axi_req.b_ready) stable = 1'b0;
        end
        n_cmp++; if (!stable) begin n_err++; $display("FAIL col_hold: got p %h want %h held, b_ready low", rsp.p, exp_q[0]); end
        req.p_ready = 1'b1;
        e = exp_q.pop_front();
        n_cmp++; if (rsp.p_valid !== 1'b1 || rsp.p !== e) begin n_err++; $display("FAIL col_rsp_r: got %h want %h", rsp.p, e); end
        n = 0;
        @(negedge clk_i);
        while (!axi_req.b_ready && n < 20) begin @(negedge clk_i); n++; end
        @(posedge clk_i); #1; axi_rsp.b_valid = 1'b0;
        wait_rsp(ok);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || rsp.p !== e) begin n_err++; $display("FAIL col_rsp_b: got %h want %h", rsp.p, e); end
        @(negedge clk_i);
        n_cmp++; if (rsp.p_valid !== 1'b0) begin n_err++; $display("FAIL col_no_dup: got p_valid %b want 0", rsp.p_valid); end
        // entry 0 still outstanding: complete it with a slave error
        exp_q.push_back('{data: {4{32'hBAD0_0000}}, error: 1'b1, user: u0});
        drive_resp(1'b1, 0, {4{32'hBAD0_0000}}, AxiRespSlvErr, ok);
        wait_rsp(ok);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || rsp.p !== e) begin n_err++; $display("FAIL slverr_rsp: got %h want %h", rsp.p, e); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL slverr_freed: got busy %b want 0", busy); end
    endtask

    task automatic test_reset_midop();
        bit ok; int lat; axi_ar_chan_t ar; cache_trans_rsp_chan_t e;
        refill_user_t u = '{bank_id: 4'd7, info: '{depth: 4'd7, way: 2'd3}};
        send_req(32'hB000_0000, 1'b1, {4{32'hCAFE_F00D}}, 16'hF0F0, u, ok);
        @(negedge clk_i);
        axi_rsp.aw_ready = 1'b1;
        @(posedge clk_i); #1; axi_rsp.aw_ready = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if ({axi_req.aw_valid, axi_req.w_valid} !== 2'b01) begin
            n_err++; $display("FAIL mid_aw_done: got %b want 01", {axi_req.aw_valid, axi_req.w_valid});
        end
        #1 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({rsp.q_ready, rsp.p_valid, axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, busy} !== 6'b0) begin
            n_err++; $display("FAIL mid_reset_clear: got %b want 000000",
                {rsp.q_ready, rsp.p_valid, axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, busy});
        end
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        send_req(32'hB000_0040, 1'b0, '0, '0, u, ok);
        take_ar(ar, lat, ok);
        n_cmp++; if (!ok || ar.id !== 3'd0) begin n_err++; $display("FAIL mid_new_id: got %0d want 0", ar.id); end
        exp_q.push_back('{data: {4{32'h7777_0001}}, error: 1'b0, user: u});
        drive_resp(1'b1, 0, {4{32'h7777_0001}}, AxiRespOkay, ok);
        wait_rsp(ok);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || rsp.p !== e) begin n_err++; $display("FAIL mid_rsp: got %h want %h", rsp.p, e); end
    endtask

    initial begin
        req = '0;
        req.p_ready = 1'b1;
        axi_rsp = '0;
        test_reset();
        test_read();
        test_write();
        test_full();
        test_collision();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
